bcast_router: RTL
=================

BCAST_ROUTER -- requirements
Module: bcast_router

Interface
REQ-001 SHALL have parameter nbits, default 32: message width in bits, legal range 8..64.
REQ-002 SHALL have parameter noutputs, default 8: number of output ports, legal range 2..16.
REQ-003 SHALL have parameter qdepth, default 2: entries per output queue, legal range 2..8.
REQ-004 SHALL have parameter cnt_nbits, default 16: width of the drop counter.
REQ-005 SHALL define localparam sw = $clog2(noutputs): the destination field is istream_msg[nbits-1 : nbits-sw].
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 istream_val  input  1  input message valid.
REQ-009 istream_msg  input  nbits  input message; the top sw bits select the destination.
REQ-010 istream_bcast  input  1  broadcast request, qualified by istream_val.
REQ-011 istream_rdy  output  1  router can accept the current input this cycle.
REQ-012 ostream_val  output  1 x [0:noutputs-1]  per-port output valid.
REQ-013 ostream_msg  output  nbits x [0:noutputs-1]  per-port output message.
REQ-014 ostream_rdy  input  1 x [0:noutputs-1]  per-port consumer ready.
REQ-015 drop_count  output  cnt_nbits  saturating count of dropped messages.

Function
REQ-016 SHALL contain one independent FIFO of qdepth entries per output port, so a stalled port does not block traffic to other ports.
REQ-017 Transfer on input SHALL occur when istream_val && istream_rdy are both high at a rising clk edge.
REQ-018 Transfer on port i SHALL occur when ostream_val[i] && ostream_rdy[i] are both high at a rising clk edge.
REQ-019 Unicast (istream_bcast=0, dest<noutputs): istream_rdy SHALL equal "queue[dest] not full"; a transfer writes the full message into queue[dest] only.
REQ-020 Broadcast (istream_bcast=1): istream_rdy SHALL be high only when every queue is not full; a transfer writes the message into all queues in the same cycle (all-or-nothing, never a partial broadcast).
REQ-021 Invalid destination (istream_bcast=0, dest>=noutputs; possible only when noutputs is not a power of 2): istream_rdy SHALL be 1; the transfer writes no queue and increments drop_count.
REQ-022 drop_count SHALL saturate at 2^cnt_nbits-1 and never wrap.
REQ-023 istream_rdy SHALL be a combinational function of istream_msg, istream_bcast and queue occupancy; it SHALL NOT depend on istream_val or on ostream_rdy.
REQ-024 A full queue SHALL NOT accept a write, even in a cycle where it is also dequeued (no full-queue bypass).
REQ-025 ostream_val[i] SHALL be high exactly when queue i is non-empty, and ostream_msg[i] SHALL be the head entry of queue i, driven from storage with no combinational path from the inputs.
REQ-026 Latency from input transfer to ostream_val[i] high SHALL be exactly 1 cycle when queue i was empty.
REQ-027 Order SHALL be preserved per port, with broadcast and unicast messages interleaved on each port in input-acceptance order.
REQ-028 A simultaneous enqueue and dequeue on a non-full queue SHALL leave its occupancy unchanged and keep the entries in order.
REQ-029 Queue pointers SHALL wrap modulo qdepth; qdepth values that are not powers of 2 SHALL work correctly.
REQ-030 Ready on ports not holding data SHALL have no effect on the router state.

Reset
REQ-031 Assertion of reset (low) SHALL immediately, independent of clk, empty all queues, clear all storage to 0, and clear drop_count to 0.
REQ-032 While reset is low: ostream_val all 0, ostream_msg all 0, drop_count 0, and no transfer occurs.
REQ-033 Reset asserted mid-operation SHALL discard all queued messages, including a broadcast that is partly drained.
REQ-034 After reset deasserts, istream_rdy SHALL be 1 for any legal input, because all queues are empty.

Verification
REQ-035 Unicast (nbits=32, noutputs=8): send msg 0x6000_00AA -> the next cycle ostream_val[3]=1 with msg 0x6000_00AA, and all other ostream_val are 0.
REQ-036 Non-blocking: hold ostream_rdy[2]=0 and send 3 messages to port 2 (qdepth=2) -> istream_rdy drops on the 3rd; a message to port 5 is then accepted and delivered the next cycle.
REQ-037 Broadcast: send istream_bcast=1, msg 0x1234_5678, with all ports ready -> all 8 ostream_val are high the next cycle with the same message; if any one queue is full, istream_rdy=0 and no queue is written.
REQ-038 Drop: noutputs=5, dest=6 -> accepted with istream_rdy=1, no ostream_val rises, drop_count goes 0->1; with cnt_nbits=2, four drops leave drop_count=3.
REQ-039 Wrap/concurrency: stream 20 sequential messages to port 0 with ostream_rdy[0]=1 -> all 20 are received in order at one per cycle, and occupancy never exceeds 1.
REQ-040 Async reset: with 2 entries queued, pull reset low between clock edges -> ostream_val is all 0 before the next edge, and istream_rdy=1 after release.

Source files
------------

// File: rtl/bcast_router.sv
// bcast_router: one input stream routed to noutputs independent FIFOs.
// Unicast writes one queue, broadcast writes all queues or none, and an
// out-of-range destination is accepted and counted as a drop.
module bcast_router #(
  parameter int nbits     = 32,
  parameter int noutputs  = 8,
  parameter int qdepth    = 2,
  parameter int cnt_nbits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  input  logic [nbits-1:0]     istream_msg,
  input  logic                 istream_bcast,
  output logic                 istream_rdy,
  output logic                 ostream_val [0:noutputs-1],
  output logic [nbits-1:0]     ostream_msg [0:noutputs-1],
  input  logic                 ostream_rdy [0:noutputs-1],
  output logic [cnt_nbits-1:0] drop_count
);

  localparam int sw     = $clog2(noutputs);
  localparam int pw     = $clog2(qdepth);
  localparam int cw     = $clog2(qdepth + 1);
  localparam int nslots = 1 << sw;

  logic [nbits-1:0]    mem    [noutputs][qdepth];
  logic [pw-1:0]       rd_ptr [noutputs];
  logic [pw-1:0]       wr_ptr [noutputs];
  logic [cw-1:0]       occ    [noutputs];

  logic [sw-1:0]       dest;
  logic                dest_ok;
  logic [nslots-1:0]   full_slot;
  logic                all_room;
  logic                xfer;
  logic                drop_en;
  logic [noutputs-1:0] wr_en;
  logic [noutputs-1:0] rd_en;

  // Pointers wrap at qdepth, which need not be a power of two.
  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (p == pw'(qdepth - 1)) ? '0 : p + pw'(1);
  endfunction

  assign dest    = istream_msg[nbits-1 -: sw];
  assign dest_ok = (int'(dest) < noutputs);

  // Full flags padded out to every encodable destination, so unused codes read as not full.
  always_comb begin
    full_slot = '0;
    all_room  = 1'b1;
    for (int i = 0; i < noutputs; i++) begin
      full_slot[i] = (occ[i] == cw'(qdepth));
      if (full_slot[i]) all_room = 1'b0;
    end
  end

  // Ready depends only on message, broadcast flag and occupancy.
  always_comb begin
    if (istream_bcast)  istream_rdy = all_room;
    else if (dest_ok)   istream_rdy = ~full_slot[dest];
    else                istream_rdy = 1'b1;
  end

  assign xfer    = istream_val && istream_rdy;
  assign drop_en = xfer && !istream_bcast && !dest_ok;

  // Per-port write and read strobes.
  always_comb begin
    for (int i = 0; i < noutputs; i++) begin
      wr_en[i] = xfer && (istream_bcast || (dest_ok && (int'(dest) == i)));
      rd_en[i] = ostream_val[i] && ostream_rdy[i];
    end
  end

  // Queue storage, pointers and occupancy; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < noutputs; i++) begin
        for (int k = 0; k < qdepth; k++) mem[i][k] <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < noutputs; i++) begin
        if (wr_en[i]) begin
          mem[i][wr_ptr[i]] <= istream_msg;
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (rd_en[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        case ({wr_en[i], rd_en[i]})
          2'b10:   occ[i] <= occ[i] + cw'(1);
          2'b01:   occ[i] <= occ[i] - cw'(1);
          default: occ[i] <= occ[i];
        endcase
      end
    end
  end

  // Saturating drop counter for invalid destinations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                drop_count <= '0;
    else if (drop_en && (drop_count != '1))    drop_count <= drop_count + cnt_nbits'(1);
  end

  // Outputs come straight from queue state: valid from occupancy, data from the head slot.
  always_comb begin
    for (int i = 0; i < noutputs; i++) begin
      ostream_val[i] = (occ[i] != '0);
      ostream_msg[i] = mem[i][rd_ptr[i]];
    end
  end

endmodule
